obi_mem_arb: RTL and testbench
==============================

OBI_MEM_ARB -- requirements
Module: obi_mem_arb

Interface
REQ-001 SHALL have parameter NPORTS, default 2, number of request ports (1..8).
REQ-002 SHALL have parameter DEPTH_WORDS, default 4096, number of 32-bit storage words.
REQ-003 SHALL have parameter LATENCY, default 1, cycles from grant to rvalid (1..4).
REQ-004 SHALL have parameter FLAG_ADDR, default 32'h0000_FFF0, byte address of the flag register.
REQ-005 SHALL have parameter RESULT_ADDR, default 32'h0000_FFF4, byte address of the result register.
REQ-006 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port port_req_i  input  NPORTS  per-port request.
REQ-009 SHALL have port port_gnt_o  output  NPORTS  per-port grant, at most one bit high.
REQ-010 SHALL have port port_rvalid_o  output  NPORTS  per-port response valid.
REQ-011 SHALL have port port_addr_i  input  NPORTS x 32  byte addresses.
REQ-012 SHALL have port port_we_i  input  NPORTS  write enable (1 = write).
REQ-013 SHALL have port port_be_i  input  NPORTS x 4  byte enables.
REQ-014 SHALL have port port_wdata_i  input  NPORTS x 32  write data.
REQ-015 SHALL have port port_rdata_o  output  NPORTS x 32  read data, valid with rvalid.
REQ-016 SHALL have port port_err_o  output  NPORTS  error flag, valid with rvalid.
REQ-017 SHALL have port mem_flag_o  output  32  flag register contents.
REQ-018 SHALL have port mem_result_o  output  32  result register contents.

Function
REQ-019 SHALL grant at most one requesting port per cycle; port_gnt_o is combinational from port_req_i and the round-robin pointer.
REQ-020 SHALL search from the pointer upward (modulo NPORTS) and grant the first port with req high; no req means no grant and no pointer change.
REQ-021 SHALL set the pointer to (granted port + 1) mod NPORTS on every grant.
REQ-022 SHALL never assert gnt to a port whose req is low; an ungranted port keeps its request pending without penalty.
REQ-023 SHALL assert port_rvalid_o for the granted port for exactly one cycle, exactly LATENCY cycles after the grant cycle, regardless of later grants.
REQ-024 SHALL support one new grant every cycle; responses return in grant order through a LATENCY-deep pipeline of {valid, port id, rdata, err}.
REQ-025 SHALL ignore addr[1:0]; word index = addr[31:2].
REQ-026 SHALL, on a granted write to a storage word, update only the bytes whose be bit is 1; be = 4'b0000 writes nothing yet still returns rvalid.
REQ-027 SHALL return rdata = 0 and err = 0 on write responses.
REQ-028 SHALL return the stored word on a read; a read granted in the cycle after a write to the same word returns the new data.
REQ-029 SHALL decode FLAG_ADDR and RESULT_ADDR before storage: writes update mem_flag_o/mem_result_o (byte-enabled) on the grant edge, reads return the register value, and storage is untouched.
REQ-030 SHALL treat a word index >= DEPTH_WORDS (excluding REQ-029 addresses) as out of range: no state change, response rdata = 0, err = 1.
REQ-031 SHALL drive port_rdata_o and port_err_o to 0 on any port whose rvalid is low.

Reset
REQ-032 SHALL, while rst_ni = 0, immediately clear all pipeline valids, pointer (0), mem_flag_o (0), mem_result_o (0); port_gnt_o and port_rvalid_o SHALL be 0.
REQ-033 SHALL drop in-flight responses on reset mid-operation; no rvalid from pre-reset grants after release.
REQ-034 SHALL leave storage contents unchanged by reset.

Verification
REQ-035 SHALL cover: NPORTS=2, LATENCY=1, port0 writes 32'hDEADBEEF be=4'hF to 0x10, then reads 0x10 -> gnt same cycle, rvalid next cycle, rdata 32'hDEADBEEF, err 0.
REQ-036 SHALL cover: both ports request continuously from pointer 0 -> grants alternate 0,1,0,1; each rvalid on its own port LATENCY cycles after its grant.
REQ-037 SHALL cover: word 0x20 = 32'h11223344, write be=4'b0101 data 32'hAABBCCDD, read back -> 32'h11BB33DD.
REQ-038 SHALL cover: LATENCY=3, back-to-back reads of 4 addresses -> 4 consecutive rvalids starting 3 cycles after first grant, in order.
REQ-039 SHALL cover: write 32'h1 to FLAG_ADDR and 32'h2A to RESULT_ADDR -> mem_flag_o=1, mem_result_o=32'h2A the cycle after each grant; read of DEPTH_WORDS*4 -> err 1, rdata 0.
REQ-040 SHALL cover: rst_ni low while 2 responses in flight (LATENCY=3) -> no rvalid after release, pointer 0, mem_flag_o 0, prior storage data still readable.

Source files
------------

// File: rtl/obi_mem_arb.sv
// obi_mem_arb: round-robin arbiter for NPORTS OBI-style request ports in front
// of a single-ported word memory, plus two memory-mapped registers (flag and
// result). One grant per cycle. Each response travels through a LATENCY-deep
// pipeline and comes back on the port that issued the request.
module obi_mem_arb #(
    parameter int          NPORTS      = 2,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          LATENCY     = 1,
    parameter logic [31:0] FLAG_ADDR   = 32'h0000_FFF0,
    parameter logic [31:0] RESULT_ADDR = 32'h0000_FFF4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NPORTS-1:0]        port_req_i,
    output logic [NPORTS-1:0]        port_gnt_o,
    output logic [NPORTS-1:0]        port_rvalid_o,
    input  logic [NPORTS-1:0][31:0]  port_addr_i,
    input  logic [NPORTS-1:0]        port_we_i,
    input  logic [NPORTS-1:0][3:0]   port_be_i,
    input  logic [NPORTS-1:0][31:0]  port_wdata_i,
    output logic [NPORTS-1:0][31:0]  port_rdata_o,
    output logic [NPORTS-1:0]        port_err_o,
    output logic [31:0]              mem_flag_o,
    output logic [31:0]              mem_result_o
);

    localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    // Apply the 1-bits of be to old, taking those bytes from nw.
    function automatic logic [31:0] bmerge(input logic [31:0] old, input logic [31:0] nw,
                                           input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        end
        return r;
    endfunction

    logic [PW-1:0]   ptr_q;
    logic            gnt_any;
    logic [PW-1:0]   gnt_id;
    logic [31:0]     sel_addr, sel_wdata;
    logic [3:0]      sel_be;
    logic            sel_we;
    logic [29:0]     word;
    logic            is_flag, is_res, in_range, mem_wr;
    logic [AW-1:0]   midx;
    logic [31:0]     rsp_rdata;
    logic            rsp_err;
    logic [31:0]     flag_q, result_q;
    logic [31:0]     mem_q [DEPTH_WORDS];
    logic            unused_addr_lsbs;

    logic [LATENCY-1:0]         vld_q, err_q;
    logic [LATENCY-1:0][PW-1:0] id_q;
    logic [LATENCY-1:0][31:0]   rdata_q;

    // Round-robin search: first requester at or above the pointer, wrapping.
    // No grant at all while reset is held.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        for (int i = 0; i < NPORTS; i++) begin
            for (int p = 0; p < NPORTS; p++) begin
                if (rst_ni && !gnt_any && port_req_i[p] && (p == ((int'(ptr_q) + i) % NPORTS))) begin
                    gnt_any = 1'b1;
                    gnt_id  = PW'(p);
                end
            end
        end
    end

    // One-hot grant vector and mux of the granted port's request fields.
    always_comb begin
        port_gnt_o = '0;
        sel_addr   = '0;
        sel_wdata  = '0;
        sel_be     = '0;
        sel_we     = 1'b0;
        for (int p = 0; p < NPORTS; p++) begin
            if (gnt_any && (gnt_id == PW'(p))) begin
                port_gnt_o[p] = 1'b1;
                sel_addr      = port_addr_i[p];
                sel_wdata     = port_wdata_i[p];
                sel_be        = port_be_i[p];
                sel_we        = port_we_i[p];
            end
        end
    end

    // Address decode (registers shadow storage) and response for the grant.
    always_comb begin
        unused_addr_lsbs = ^sel_addr[1:0];
        word      = sel_addr[31:2];
        is_flag   = (word == FLAG_ADDR[31:2]);
        is_res    = (word == RESULT_ADDR[31:2]) && !is_flag;
        in_range  = !is_flag && !is_res && ({2'b00, word} < 32'(DEPTH_WORDS));
        midx      = word[AW-1:0];
        mem_wr    = gnt_any && sel_we && in_range;
        rsp_rdata = '0;
        rsp_err   = 1'b0;
        if (gnt_any) begin
            rsp_err = !(is_flag || is_res || in_range);
            if (!sel_we) begin
                if (is_flag)       rsp_rdata = flag_q;
                else if (is_res)   rsp_rdata = result_q;
                else if (in_range) rsp_rdata = mem_q[midx];
            end
        end
    end

    // Storage is deliberately outside reset so its contents survive it.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_wr && sel_be[b]) mem_q[midx][8*b +: 8] <= sel_wdata[8*b +: 8];
        end
    end

    // Pointer advance and flag/result register writes on the grant edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q    <= '0;
            flag_q   <= '0;
            result_q <= '0;
        end else if (gnt_any) begin
            ptr_q <= (gnt_id == PW'(NPORTS - 1)) ? '0 : gnt_id + 1'b1;
            if (sel_we && is_flag) flag_q   <= bmerge(flag_q, sel_wdata, sel_be);
            if (sel_we && is_res)  result_q <= bmerge(result_q, sel_wdata, sel_be);
        end
    end

    // Response pipeline; reset flushes everything in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q   <= '0;
            id_q    <= '0;
            rdata_q <= '0;
            err_q   <= '0;
        end else begin
            vld_q[0]   <= gnt_any;
            id_q[0]    <= gnt_id;
            rdata_q[0] <= rsp_rdata;
            err_q[0]   <= rsp_err;
            for (int k = 1; k < LATENCY; k++) begin
                vld_q[k]   <= vld_q[k-1];
                id_q[k]    <= id_q[k-1];
                rdata_q[k] <= rdata_q[k-1];
                err_q[k]   <= err_q[k-1];
            end
        end
    end

    // Steer the pipeline tail to its port; idle ports read as zero.
    always_comb begin
        port_rvalid_o = '0;
        port_rdata_o  = '0;
        port_err_o    = '0;
        for (int p = 0; p < NPORTS; p++) begin
            if (vld_q[LATENCY-1] && (id_q[LATENCY-1] == PW'(p))) begin
                port_rvalid_o[p] = 1'b1;
                port_rdata_o[p]  = rdata_q[LATENCY-1];
                port_err_o[p]    = err_q[LATENCY-1];
            end
        end
    end

    assign mem_flag_o   = flag_q;
    assign mem_result_o = result_q;

endmodule

// File: tb/tb_obi_mem_arb.sv
// Bench for obi_mem_arb: instance 0 has LATENCY=1, instance 1 has LATENCY=3.
// Stimulus pushes expected responses (port, data, err, due cycle) into a
// per-instance queue; a negedge monitor pops and compares on every rvalid.
module tb_obi_mem_arb;

    localparam int          NP    = 2;
    localparam int          DEPTH = 4096;
    localparam logic [31:0] FLAG  = 32'h0000_FFF0;
    localparam logic [31:0] RES   = 32'h0000_FFF4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]                 rst_n;
    logic [1:0][NP-1:0]         req, we;
    logic [1:0][NP-1:0][31:0]   addr, wdata;
    logic [1:0][NP-1:0][3:0]    be;
    wire  [1:0][NP-1:0]         gnt, rv, err;
    wire  [1:0][NP-1:0][31:0]   rdata;
    wire  [1:0][31:0]           flag, result;

    obi_mem_arb #(.NPORTS(NP), .DEPTH_WORDS(DEPTH), .LATENCY(1), .FLAG_ADDR(FLAG), .RESULT_ADDR(RES)) u_l1 (
        .clk_i(clk), .rst_ni(rst_n[0]), .port_req_i(req[0]), .port_gnt_o(gnt[0]),
        .port_rvalid_o(rv[0]), .port_addr_i(addr[0]), .port_we_i(we[0]), .port_be_i(be[0]),
        .port_wdata_i(wdata[0]), .port_rdata_o(rdata[0]), .port_err_o(err[0]),
        .mem_flag_o(flag[0]), .mem_result_o(result[0]));

    obi_mem_arb #(.NPORTS(NP), .DEPTH_WORDS(DEPTH), .LATENCY(3), .FLAG_ADDR(FLAG), .RESULT_ADDR(RES)) u_l3 (
        .clk_i(clk), .rst_ni(rst_n[1]), .port_req_i(req[1]), .port_gnt_o(gnt[1]),
        .port_rvalid_o(rv[1]), .port_addr_i(addr[1]), .port_we_i(we[1]), .port_be_i(be[1]),
        .port_wdata_i(wdata[1]), .port_rdata_o(rdata[1]), .port_err_o(err[1]),
        .mem_flag_o(flag[1]), .mem_result_o(result[1]));

    typedef struct {
        int          p;
        logic [31:0] rd;
        logic        e;
        int          due;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int lat(input int d);
        return (d == 1) ? 3 : 1;
    endfunction

    function automatic int qsize(input int d);
        return (d == 1) ? q1.size() : q0.size();
    endfunction

    task automatic push(input int d, input int p, input logic [31:0] rd, input logic e);
        exp_t x;
        x.p = p; x.rd = rd; x.e = e; x.due = cyc + lat(d);
        if (d == 1) q1.push_back(x);
        else        q0.push_back(x);
    endtask

    // Monitor: every rvalid must match the oldest expectation, on time.
    always @(negedge clk) begin : mon
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < NP; p++) begin
                if (rv[d][p] === 1'b1) begin
                    if (qsize(d) == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL unexpected_rvalid: dut %0d port %0d got rvalid, expected none (cycle %0d)", d, p, cyc);
                    end else begin
                        if (d == 1) e = q1.pop_front();
                        else        e = q0.pop_front();
                        chk("rsp_port", p, e.p);
                        chk("rsp_rdata", rdata[d][p], e.rd);
                        chk("rsp_err", 32'(err[d][p]), 32'(e.e));
                        chk("rsp_cycle", cyc, e.due);
                    end
                end else begin
                    chk("idle_rdata", rdata[d][p], 32'h0);
                    chk("idle_err", 32'(err[d][p]), 32'h0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr(input int d);
        req[d] = '0; we[d] = '0; addr[d] = '0; be[d] = '0; wdata[d] = '0;
    endtask

    // Single-port request for one cycle; grant must be immediate.
    task automatic op(input int d, input int p, input logic w, input logic [31:0] a, input logic [3:0] b,
                      input logic [31:0] wd, input logic [31:0] erd, input logic eerr);
        tick();
        clr(d);
        req[d][p] = 1'b1; we[d][p] = w; addr[d][p] = a; be[d][p] = b; wdata[d][p] = wd;
        #1 chk("gnt_single", 32'(gnt[d]), 32'(1 << p));
        push(d, p, erd, eerr);
    endtask

    task automatic wr(input int d, input int p, input logic [31:0] a, input logic [3:0] b,
                      input logic [31:0] wd, input logic eerr);
        op(d, p, 1'b1, a, b, wd, 32'h0, eerr);
    endtask

    task automatic rd(input int d, input int p, input logic [31:0] a, input logic [31:0] erd, input logic eerr);
        op(d, p, 1'b0, a, 4'hF, 32'h0, erd, eerr);
    endtask

    task automatic idle(input int d);
        tick();
        clr(d);
    endtask

    task automatic drain(input int d);
        idle(d);
        for (int i = 0; i < 10 && qsize(d) != 0; i++) tick();
        chk("drain_queue_empty", qsize(d), 0);
    endtask

    initial begin
        rst_n = '1;
        clr(0); clr(1);
        #2 rst_n = '0;
        req[0] = '1; req[1] = '1;
        @(negedge clk);
        chk("rst_gnt0", 32'(gnt[0]), 32'h0);
        chk("rst_gnt1", 32'(gnt[1]), 32'h0);
        chk("rst_flag0", flag[0], 32'h0);
        chk("rst_result0", result[0], 32'h0);
        chk("rst_flag1", flag[1], 32'h0);
        chk("rst_result1", result[1], 32'h0);
        tick();
        clr(0); clr(1);
        rst_n = '1;

        // Both ports write continuously from pointer 0: grants 0,1,0,1
        tick();
        req[0] = 2'b11; we[0] = 2'b11; be[0][0] = 4'hF; be[0][1] = 4'hF;
        addr[0][0] = 32'h100; wdata[0][0] = 32'h0A0A_0001;
        addr[0][1] = 32'h104; wdata[0][1] = 32'h0B0B_0002;
        for (int k = 0; k < 4; k++) begin
            if (k != 0) tick();
            #1 chk("rr_gnt", 32'(gnt[0]), (k % 2 == 1) ? 32'h2 : 32'h1);
            push(0, k % 2, 32'h0, 1'b0);
        end
        idle(0);

        // Write then read same word back-to-back
        wr(0, 0, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0);
        rd(0, 0, 32'h10, 32'hDEADBEEF, 1'b0);

        // Pointer now 1: simultaneous reads grant port 1 first, then port 0
        tick();
        clr(0);
        req[0] = 2'b11; be[0][0] = 4'hF; be[0][1] = 4'hF;
        addr[0][0] = 32'h100; addr[0][1] = 32'h104;
        #1 chk("rr_ptr1_gnt", 32'(gnt[0]), 32'h2);
        push(0, 1, 32'h0B0B_0002, 1'b0);
        tick();
        req[0][1] = 1'b0;
        #1 chk("rr_ptr1_gnt2", 32'(gnt[0]), 32'h1);
        push(0, 0, 32'h0A0A_0001, 1'b0);

        // Byte enables, ignored low address bits, be=0
        wr(0, 0, 32'h20, 4'hF, 32'h11223344, 1'b0);
        wr(0, 1, 32'h20, 4'b0101, 32'hAABBCCDD, 1'b0);
        rd(0, 0, 32'h20, 32'h11BB33DD, 1'b0);
        rd(0, 1, 32'h23, 32'h11BB33DD, 1'b0);
        wr(0, 1, 32'h20, 4'b0000, 32'hFFFFFFFF, 1'b0);
        rd(0, 0, 32'h20, 32'h11BB33DD, 1'b0);

        // Flag/result registers and out-of-range accesses
        wr(0, 0, FLAG, 4'hF, 32'h1, 1'b0);
        idle(0);
        chk("flag_after_write", flag[0], 32'h1);
        wr(0, 1, RES, 4'hF, 32'h2A, 1'b0);
        idle(0);
        chk("result_after_write", result[0], 32'h2A);
        wr(0, 0, RES, 4'b0010, 32'h0000_FF00, 1'b0);
        idle(0);
        chk("result_byte_write", result[0], 32'h0000_FF2A);
        chk("flag_unchanged", flag[0], 32'h1);
        rd(0, 1, FLAG, 32'h1, 1'b0);
        rd(0, 0, DEPTH * 4, 32'h0, 1'b1);
        wr(0, 1, DEPTH * 4 + 4, 4'hF, 32'h55, 1'b1);
        rd(0, 0, RES, 32'h0000_FF2A, 1'b0);
        drain(0);

        // LATENCY=3: four back-to-back reads return on consecutive cycles
        for (int k = 0; k < 4; k++) wr(1, 0, 32'h200 + 32'(4 * k), 4'hF, 32'h3000_0000 + 32'(k), 1'b0);
        for (int k = 0; k < 4; k++) rd(1, 1, 32'h200 + 32'(4 * k), 32'h3000_0000 + 32'(k), 1'b0);
        drain(1);

        // Reset with two reads in flight; pointer left at 1 before reset
        wr(1, 0, 32'h40, 4'hF, 32'hCAFEF00D, 1'b0);
        wr(1, 1, FLAG, 4'hF, 32'h5, 1'b0);
        rd(1, 1, 32'h200, 32'h3000_0000, 1'b0);
        rd(1, 0, 32'h40, 32'hCAFEF00D, 1'b0);
        tick();
        clr(1);
        rst_n[1] = 1'b0;
        q1.delete();
        #1 chk("midrst_flag", flag[1], 32'h0);
        chk("midrst_result", result[1], 32'h0);
        req[1] = 2'b11;
        #1 chk("midrst_gnt", 32'(gnt[1]), 32'h0);
        tick();
        tick();
        clr(1);
        rst_n[1] = 1'b1;
        for (int i = 0; i < 5; i++) tick();

        tick();
        req[1] = 2'b11; be[1][0] = 4'hF; be[1][1] = 4'hF;
        addr[1][0] = 32'h40; addr[1][1] = 32'h204;
        #1 chk("postrst_ptr_gnt", 32'(gnt[1]), 32'h1);
        push(1, 0, 32'hCAFEF00D, 1'b0);
        tick();
        req[1][0] = 1'b0;
        #1 chk("postrst_gnt2", 32'(gnt[1]), 32'h2);
        push(1, 1, 32'h3000_0001, 1'b0);
        drain(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
